// File: rtl/p_pkg.sv
// Shared constants, FSM state type and LFSR step function for the p-bit scheduler family.
package p_pkg;

  localparam int          ACT_W     = 4;
  localparam int          ACT_MAX   = 15;
  localparam int          ACT_BIAS  = 8;
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return (q >> 1) ^ (q[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/p_lfsr.sv
// 16-bit Galois LFSR that advances only when enabled; shared by the p-bit schedulers.
module p_lfsr
  import p_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= SEED;
    else if (en) q <= lfsr_next(q);
  end

endmodule

// File: rtl/p_gibbs_scheduler.sv
// Sequential Gibbs sampler: visits one p-bit per cycle, compares its activation with an
// LFSR nibble (or applies its clamp) and counts full sweeps until the programmed total.
module p_gibbs_scheduler #(
  parameter int          N_PBITS   = 5,
  parameter int          ACT_W     = p_pkg::ACT_W,
  parameter int          SWEEP_W   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         IDX_W     = (N_PBITS > 1) ? $clog2(N_PBITS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [SWEEP_W-1:0]         n_sweeps,
  input  logic [N_PBITS-1:0]         clamp_mask,
  input  logic [N_PBITS-1:0]         clamp_val,
  input  logic [N_PBITS*ACT_W-1:0]   act_in,
  output logic [N_PBITS-1:0]         state_out,
  output logic [IDX_W-1:0]           upd_idx,
  output logic                       upd_valid,
  output logic [SWEEP_W-1:0]         sweep_cnt,
  output logic                       busy,
  output logic                       done
);

  import p_pkg::*;

  fsm_t               state, state_nx;
  logic [SWEEP_W-1:0] n_lat;
  logic [15:0]        lfsr_q;
  logic [15:ACT_W]    lfsr_unused;
  logic               accept, upd, last_idx, last_sweep;
  logic [SWEEP_W-1:0] sweep_inc;
  logic [ACT_W-1:0]   act_sel;
  logic               clamp_en, clamp_bit, new_bit;
  logic [N_PBITS-1:0] sel;

  // Start and abort together in IDLE is not an accept; abort also cancels the pending update.
  assign accept     = (state == IDLE) && start && !abort;
  assign upd        = (state == SWEEP) && !abort;
  assign last_idx   = (upd_idx == IDX_W'(N_PBITS - 1));
  assign sweep_inc  = sweep_cnt + 1'b1;
  assign last_sweep = last_idx && (sweep_inc == n_lat);

  assign upd_valid  = upd;
  assign busy       = (state == SWEEP);
  assign done       = (state == DONE);

  p_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (upd),
    .q   (lfsr_q)
  );

  // Upper LFSR bits are held in reserve for wider activation formats.
  assign lfsr_unused = lfsr_q[15:ACT_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = (n_sweeps == '0) ? DONE : SWEEP;
      SWEEP:   if (abort) state_nx = IDLE;
               else if (last_sweep) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Select the visited p-bit's activation and clamp, then form its new value.
  always_comb begin
    act_sel   = '0;
    clamp_en  = 1'b0;
    clamp_bit = 1'b0;
    sel       = '0;
    for (int k = 0; k < N_PBITS; k++) begin
      if (upd_idx == IDX_W'(k)) begin
        act_sel   = act_in[k*ACT_W +: ACT_W];
        clamp_en  = clamp_mask[k];
        clamp_bit = clamp_val[k];
        sel[k]    = 1'b1;
      end
    end
    new_bit = clamp_en ? clamp_bit : (act_sel > lfsr_q[ACT_W-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_out <= '0;
      upd_idx   <= '0;
      sweep_cnt <= '0;
      n_lat     <= '0;
    end else if (accept) begin
      n_lat     <= n_sweeps;
      sweep_cnt <= '0;
      upd_idx   <= '0;
    end else if (upd) begin
      state_out <= (state_out & ~sel) | ({N_PBITS{new_bit}} & sel);
      if (last_idx) begin
        upd_idx   <= '0;
        sweep_cnt <= sweep_inc;
      end else begin
        upd_idx   <= upd_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_p_gibbs_scheduler.sv
// Self-checking bench: scenario table plus hand-written abort/reset/zero-sweep sequences,
// all compared against a behavioural Gibbs-sweep model.
module tb_p_gibbs_scheduler;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] n_sweeps;
  logic [4:0]  clamp_mask, clamp_val;
  logic [19:0] act_in;
  logic [4:0]  state_out;
  logic [2:0]  upd_idx;
  logic        upd_valid, busy, done;
  logic [15:0] sweep_cnt;

  p_gibbs_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .n_sweeps   (n_sweeps),
    .clamp_mask (clamp_mask),
    .clamp_val  (clamp_val),
    .act_in     (act_in),
    .state_out  (state_out),
    .upd_idx    (upd_idx),
    .upd_valid  (upd_valid),
    .sweep_cnt  (sweep_cnt),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: p-bit vector and the random source, stepped once per update.
  logic [15:0] m_lfsr;
  logic [4:0]  m_state;

  function automatic logic [15:0] rng_step(input logic [15:0] q);
    int v;
    int lsb;
    v   = int'(q);
    lsb = v % 2;
    v   = v / 2;
    if (lsb == 1) v = v ^ 32'hB400;
    return v[15:0];
  endfunction

  typedef struct {
    int         n;          // sweeps
    int         act;        // activation for all p-bits; negative = random per update
    logic [4:0] mask;
    logic [4:0] cval;
    bit         mid_start;  // pulse start during the run
    bit         know;       // exp holds a fixed expected final state
    logic [4:0] exp;
  } vec_t;

  vec_t       tbl[5];
  logic [4:0] rec_q[$];
  bit         recording = 1'b0;
  bit         replay    = 1'b0;
  int         rep_i     = 0;
  int         ones      = 0;

  // Called at the falling edge inside an update cycle for p-bit i.
  task automatic upd_step(input int i, input logic [19:0] a, input logic [4:0] mask,
                          input logic [4:0] cval);
    logic nb;
    act_in = a;
    check("upd_valid", 32'(upd_valid), 32'd1);
    check("upd_idx",   32'(upd_idx),   32'(i));
    check("busy",      32'(busy),      32'd1);
    check("done_mid",  32'(done),      32'd0);
    if (mask[i]) nb = cval[i];
    else         nb = (a[i*4 +: 4] > m_lfsr[3:0]);
    m_state[i] = nb;
    m_lfsr     = rng_step(m_lfsr);
    @(negedge clk);
    check("state_out", 32'(state_out), 32'(m_state));
    if (state_out[i]) ones++;
    if (recording) rec_q.push_back(state_out);
    if (replay) begin
      if (rep_i < rec_q.size()) check("replay", 32'(state_out), 32'(rec_q[rep_i]));
      else check("replay_len", 32'(rep_i), 32'(rec_q.size()));
      rep_i++;
    end
  endtask

  task automatic do_run(input vec_t v);
    logic [19:0] a;
    @(negedge clk);
    start = 1'b1; n_sweeps = 16'(v.n); clamp_mask = v.mask; clamp_val = v.cval;
    @(negedge clk);
    start = 1'b0;
    ones  = 0;
    for (int u = 0; u < v.n * N; u++) begin
      if (v.act < 0) a = 20'($urandom);
      else           a = {5{v.act[3:0]}};
      if (v.mid_start && u == 3) begin start = 1'b1; n_sweeps = 16'd1; end
      else start = 1'b0;
      upd_step(u % N, a, v.mask, v.cval);
    end
    start = 1'b0;
    check("done_pulse", 32'(done),      32'd1);
    check("busy_done",  32'(busy),      32'd0);
    check("upd_v_done", 32'(upd_valid), 32'd0);
    check("sweep_cnt",  32'(sweep_cnt), 32'(v.n));
    if (v.know) check("final_state", 32'(state_out), 32'(v.exp));
    @(negedge clk);
    check("done_once",  32'(done),      32'd0);
    check("state_hold", 32'(state_out), 32'(m_state));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; n_sweeps = '0;
    clamp_mask = '0; clamp_val = '0; act_in = '0;
    m_lfsr = 16'hACE1; m_state = '0;

    tbl[0] = '{4,  15, 5'b00000, 5'b00000, 1'b0, 1'b0, 5'b00000};
    tbl[1] = '{3,  0,  5'b00000, 5'b00000, 1'b0, 1'b1, 5'b00000};
    tbl[2] = '{1,  0,  5'b10101, 5'b10001, 1'b0, 1'b1, 5'b10001};
    tbl[3] = '{2,  -1, 5'b00110, 5'b00100, 1'b1, 1'b0, 5'b00000};
    tbl[4] = '{400, 8, 5'b00000, 5'b00000, 1'b0, 1'b0, 5'b00000};

    #2;
    check("rst_state",  32'(state_out), 32'd0);
    check("rst_idx",    32'(upd_idx),   32'd0);
    check("rst_valid",  32'(upd_valid), 32'd0);
    check("rst_sweep",  32'(sweep_cnt), 32'd0);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_done",   32'(done),      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    recording = 1'b1;
    do_run(tbl[0]);
    recording = 1'b0;
    for (int k = 1; k < 5; k++) begin
      do_run(tbl[k]);
      if (k == 4) check("ones_frac_ok", 32'(ones >= 920 && ones <= 1080), 32'd1);
    end

    // Zero sweeps: straight to DONE with no update cycles.
    @(negedge clk);
    start = 1'b1; n_sweeps = 16'd0;
    @(negedge clk);
    start = 1'b0;
    check("zero_done",  32'(done),      32'd1);
    check("zero_valid", 32'(upd_valid), 32'd0);
    check("zero_busy",  32'(busy),      32'd0);
    check("zero_sweep", 32'(sweep_cnt), 32'd0);
    check("zero_state", 32'(state_out), 32'(m_state));
    @(negedge clk);
    check("zero_once",  32'(done),      32'd0);

    // Start together with abort in IDLE is not accepted.
    start = 1'b1; abort = 1'b1; n_sweeps = 16'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("sa_busy",  32'(busy),      32'd0);
    check("sa_done",  32'(done),      32'd0);
    check("sa_valid", 32'(upd_valid), 32'd0);

    // Abort in the cycle of update 7: no update there, IDLE next, no done.
    start = 1'b1; n_sweeps = 16'd2; clamp_mask = '0;
    @(negedge clk);
    start = 1'b0;
    for (int u = 0; u < 7; u++) upd_step(u % N, 20'($urandom), 5'b00000, 5'b00000);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy",  32'(busy),      32'd0);
    check("ab_done",  32'(done),      32'd0);
    check("ab_valid", 32'(upd_valid), 32'd0);
    check("ab_state", 32'(state_out), 32'(m_state));
    check("ab_sweep", 32'(sweep_cnt), 32'd1);
    @(negedge clk);
    check("ab_done2", 32'(done),      32'd0);
    do_run(tbl[1]);

    // Reset in the middle of a run, then the first run must repeat exactly.
    start = 1'b1; n_sweeps = 16'd3; act_in = {5{4'd8}};
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mr_state", 32'(state_out), 32'd0);
    check("mr_idx",   32'(upd_idx),   32'd0);
    check("mr_valid", 32'(upd_valid), 32'd0);
    check("mr_sweep", 32'(sweep_cnt), 32'd0);
    check("mr_busy",  32'(busy),      32'd0);
    check("mr_done",  32'(done),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = 16'hACE1; m_state = '0;
    replay = 1'b1;
    do_run(tbl[0]);
    replay = 1'b0;
    check("replay_cnt", 32'(rep_i), 32'(rec_q.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
